imem_port_arbiter: RTL and testbench

//  Shares the single-port instruction memory between the core's fetch stage (read) and the program loader (write).
//  - Grants at most one access per cycle.
//  - Drives the memory's addr / wr_en / i_data and returns o_data to the fetch stage, with valid tagging.
//  - Sits between fetch/loader and instr memory; uses fixed priority plus a starvation override.

---
 rtl/imem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_imem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: arbitrates the single-port instruction memory between
// fetch reads and loader writes. Fixed priority (WR_PRIO) plus a starvation
// override after MAX_WAIT lost cycles. The loader can hold exclusive
// ownership (LOCK) with wr_lock.
// Optional macro IMEM_ARB_PERF_EN adds the perf_rd_cnt, perf_wr_cnt and
// perf_stall_cnt outputs.
module imem_port_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WR_PRIO  = 0,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_lock,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_rd_cnt,
    output logic [15:0]       perf_wr_cnt,
    output logic [15:0]       perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_LOCK
    } state_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [3:0]        fwait_q, fwait_d;
    logic [3:0]        wwait_q, wwait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rvalid_q, rvalid_d;
    logic              locked_q, locked_d;

`ifdef IMEM_ARB_PERF_EN
    logic [15:0] perf_rd_q, perf_rd_d;
    logic [15:0] perf_wr_q, perf_wr_d;
    logic [15:0] perf_stall_q, perf_stall_d;
`endif

    // Grant selection: lock blocks fetch, otherwise priority with starvation override
    always_comb begin
        fetch_gnt = 1'b0;
        wr_gnt    = 1'b0;
        if (rst_n) begin
            if (state_q == ST_LOCK) begin
                wr_gnt = wr_req;
            end else if (fetch_req && wr_req) begin
                if (WR_PRIO != 0) begin
                    if (fwait_q >= MAX_WAIT_C) fetch_gnt = 1'b1;
                    else                       wr_gnt    = 1'b1;
                end else begin
                    if (wwait_q >= MAX_WAIT_C) wr_gnt    = 1'b1;
                    else                       fetch_gnt = 1'b1;
                end
            end else begin
                fetch_gnt = fetch_req;
                wr_gnt    = wr_req;
            end
        end
    end

    // Memory drive, wait counters, next FSM state and perf counters
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wr_en = 1'b0;
        if (wr_gnt) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            mem_wr_en = 1'b1;
        end else if (fetch_gnt) begin
            mem_addr = fetch_addr;
        end
        addr_d  = mem_addr;
        wdata_d = mem_wdata;

        if (!fetch_req || fetch_gnt)   fwait_d = '0;
        else if (fwait_q >= MAX_WAIT_C) fwait_d = fwait_q;
        else                           fwait_d = fwait_q + 4'd1;

        if (!wr_req || wr_gnt)         wwait_d = '0;
        else if (wwait_q >= MAX_WAIT_C) wwait_d = wwait_q;
        else                           wwait_d = wwait_q + 4'd1;

        state_d = ST_IDLE;
        if (state_q == ST_LOCK) begin
            state_d = wr_lock ? ST_LOCK : ST_IDLE;
        end else if (wr_gnt) begin
            state_d = wr_lock ? ST_LOCK : ST_WR;
        end else if (fetch_gnt) begin
            state_d = ST_RD;
        end
        rvalid_d = (state_d == ST_RD);
        locked_d = (state_d == ST_LOCK);

`ifdef IMEM_ARB_PERF_EN
        perf_rd_d    = perf_rd_q + {15'd0, fetch_gnt};
        perf_wr_d    = perf_wr_q + {15'd0, wr_gnt};
        perf_stall_d = perf_stall_q +
                       {15'd0, (fetch_req && !fetch_gnt) || (wr_req && !wr_gnt)};
`endif
    end

    // All state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            fwait_q  <= '0;
            wwait_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            locked_q <= 1'b0;
`ifdef IMEM_ARB_PERF_EN
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            fwait_q  <= fwait_d;
            wwait_q  <= wwait_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            locked_q <= locked_d;
`ifdef IMEM_ARB_PERF_EN
            perf_rd_q    <= perf_rd_d;
            perf_wr_q    <= perf_wr_d;
            perf_stall_q <= perf_stall_d;
`endif
        end
    end

    assign fetch_rvalid = rvalid_q;
    assign fetch_rdata  = mem_rdata;
    assign locked       = locked_q;

`ifdef IMEM_ARB_PERF_EN
    assign perf_rd_cnt    = perf_rd_q;
    assign perf_wr_cnt    = perf_wr_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios followed by randomized
// protocol-respecting traffic, checked against a cycle-level reference model
// and a read-data scoreboard.
module tb_imem_port_arbiter;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [DW-1:0] fetch_rdata;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_lock;
    logic          wr_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          locked;
`ifdef IMEM_ARB_PERF_EN
    logic [15:0]   perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WR_PRIO(0), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lock(wr_lock),
        .wr_gnt(wr_gnt),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked)
`ifdef IMEM_ARB_PERF_EN
        , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    function automatic logic [DW-1:0] seed_word(input int unsigned a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Single-port memory with registered read, preloaded on the first edge
    logic [DW-1:0] mem [256];
    logic          mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
            mem_init_done <= 1'b1;
        end else begin
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [DW-1:0] ref_mem [256];
    bit            m_lock = 1'b0;
    int unsigned   m_fwait = 0, m_wwait = 0;
    logic [AW-1:0] m_last_addr = '0;
    bit            m_addr_known = 1'b0;
    bit            last_ef = 1'b0, last_ew = 1'b0;
    logic [15:0]   m_rd = '0, m_wr = '0, m_stall = '0;

    initial for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);

    // Model: predict grants and memory drive from current inputs, then advance
    always @(negedge clk) begin
        bit ef, ew;
        ef = 1'b0;
        ew = 1'b0;
        if (rst_n) begin
            if (m_lock) ew = wr_req;
            else if (fetch_req && wr_req) begin
                if (m_wwait == MAXW) ew = 1'b1;
                else                 ef = 1'b1;
            end else begin
                ef = fetch_req;
                ew = wr_req;
            end
        end
        chk("fetch_gnt", 64'(fetch_gnt), 64'(ef));
        chk("wr_gnt", 64'(wr_gnt), 64'(ew));
        chk("locked", 64'(locked), 64'(m_lock));
        if (ew) begin
            chk("wr_en_on_write", 64'(mem_wr_en), 64'd1);
            chk("mem_addr_write", 64'(mem_addr), 64'(wr_addr));
            chk("mem_wdata_write", 64'(mem_wdata), 64'(wr_data));
            ref_mem[wr_addr] = wr_data;
            m_last_addr  = wr_addr;
            m_addr_known = 1'b1;
        end else if (ef) begin
            chk("wr_en_on_read", 64'(mem_wr_en), 64'd0);
            chk("mem_addr_read", 64'(mem_addr), 64'(fetch_addr));
            sb.push_back('{due: cyc + 1, data: ref_mem[fetch_addr]});
            m_last_addr  = fetch_addr;
            m_addr_known = 1'b1;
        end else begin
            chk("wr_en_idle", 64'(mem_wr_en), 64'd0);
            if (m_addr_known) chk("mem_addr_hold", 64'(mem_addr), 64'(m_last_addr));
        end
`ifdef IMEM_ARB_PERF_EN
        chk("perf_rd", 64'(perf_rd_cnt), 64'(m_rd));
        chk("perf_wr", 64'(perf_wr_cnt), 64'(m_wr));
        chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
`endif
        if (!rst_n) begin
            m_lock       = 1'b0;
            m_fwait      = 0;
            m_wwait      = 0;
            m_addr_known = 1'b0;
            m_rd         = '0;
            m_wr         = '0;
            m_stall      = '0;
        end else begin
            m_fwait = (!fetch_req || ef) ? 0 : ((m_fwait < MAXW) ? m_fwait + 1 : MAXW);
            m_wwait = (!wr_req || ew)    ? 0 : ((m_wwait < MAXW) ? m_wwait + 1 : MAXW);
            m_lock  = m_lock ? wr_lock : (ew && wr_lock);
            if (ef) m_rd++;
            if (ew) m_wr++;
            if ((fetch_req && !ef) || (wr_req && !ew)) m_stall++;
        end
        last_ef = ef;
        last_ew = ew;
    end

    // Monitor: every rvalid must match the oldest outstanding read, on time
    always @(negedge clk) begin
        if (fetch_rvalid) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rvalid_cycle", 64'(cyc), 64'(e.due));
                chk("rdata", 64'(fetch_rdata), 64'(e.data));
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("rvalid_missing", 64'd0, 64'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit fpend, wpend;
        rst_n      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = '0;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_lock    = 1'b0;
        step();
        // Reset held with a pending fetch
        step();
        step();
        rst_n = 1'b1;
        // Streaming fetch of addresses 0..3
        for (int k = 0; k < 4; k++) begin
            fetch_addr = AW'(k);
            step();
        end
        fetch_req = 1'b0;
        step();
        // Sustained contention
        fetch_req  = 1'b1;
        fetch_addr = 8'd7;
        wr_req     = 1'b1;
        wr_addr    = 8'd20;
        wr_data    = $urandom;
        for (int k = 0; k < 7; k++) step();
        fetch_req = 1'b0;
        wr_req    = 1'b0;
        step();
        // Write then immediate read of the same address
        wr_req  = 1'b1;
        wr_addr = 8'd9;
        wr_data = 32'hDEAD_BEEF;
        step();
        wr_req     = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 8'd9;
        step();
        fetch_req = 1'b0;
        step();
        step();
        // Locked burst with fetch waiting throughout
        wr_req  = 1'b1;
        wr_lock = 1'b1;
        wr_addr = 8'd0;
        wr_data = $urandom;
        step();
        fetch_req  = 1'b1;
        fetch_addr = 8'd3;
        for (int a = 1; a < 3; a++) begin
            wr_addr = AW'(a);
            wr_data = $urandom;
            step();
        end
        wr_req = 1'b0;
        step();
        wr_lock = 1'b0;
        step();
        step();
        fetch_req = 1'b0;
        step();
        // Reset while locked
        wr_req  = 1'b1;
        wr_lock = 1'b1;
        wr_addr = 8'd30;
        wr_data = $urandom;
        step();
        wr_req = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        wr_lock = 1'b0;
        step();
        step();
        // Randomized traffic respecting hold-until-granted
        fpend = 1'b0;
        wpend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (fpend && last_ef) fpend = 1'b0;
            if (wpend && last_ew) wpend = 1'b0;
            if (!fpend && ($urandom % 2 == 0)) begin
                fpend      = 1'b1;
                fetch_addr = AW'($urandom);
            end
            if (!wpend && ($urandom % 3 == 0)) begin
                wpend   = 1'b1;
                wr_addr = AW'($urandom);
                wr_data = $urandom;
            end
            if (m_lock) wr_lock = ($urandom % 4 != 0);
            else if (!wpend || last_ew) wr_lock = ($urandom % 6 == 0);
            fetch_req = fpend;
            wr_req    = wpend;
            rst_n     = ($urandom % 100 != 0);
            step();
        end
        rst_n     = 1'b1;
        fetch_req = 1'b0;
        wr_req    = 1'b0;
        wr_lock   = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
